// File: rtl/cdu_timing_gen.sv
// cdu_timing_gen: one-hot phase generator with phase-cycle divider, tap strobe and ISSI service.
// Ports:
//   _51KPHI   master clock, rising edge
//   rst_n     asynchronous active-low reset
//   en        phase advance enable
//   resync    synchronous restart of phase, divider and ISSI state
//   tap_sel   divider bit watched for tick_out
//   issi      asynchronous ISSI request level
//   faz/faz_n one-hot phase vector and its complement
//   phase_idx current phase index
//   div_cnt   phase-cycle divider
//   tick_out  strobe on 0->1 of the selected divider bit
//   wrap      strobe on divider wrap
//   issi_ph   serviced-ISSI strobe on phase ISSI_PH
//   issi_pend synchronised request waiting for service
//   issi_ovf  sticky: request merged into one already pending
module cdu_timing_gen #(
  parameter int NPHASE  = 4,
  parameter int DIV_W   = 4,
  parameter int ISSI_PH = 2
) (
  input  logic                      _51KPHI,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      resync,
  input  logic [3:0]                tap_sel,
  input  logic                      issi,
  output logic [NPHASE-1:0]         faz,
  output logic [NPHASE-1:0]         faz_n,
  output logic [$clog2(NPHASE)-1:0] phase_idx,
  output logic [DIV_W-1:0]          div_cnt,
  output logic                      tick_out,
  output logic                      wrap,
  output logic                      issi_ph,
  output logic                      issi_pend,
  output logic                      issi_ovf
);
  localparam int PW = $clog2(NPHASE);
  logic [PW-1:0]    p_q, p_d;
  logic [DIV_W-1:0] d_q, d_d;
  logic             tick_q, tick_d, wrap_q, wrap_d, pend_q, pend_d, ovf_q, ovf_d;
  // {s3, s2, s1}
  logic [2:0]       sync_q, sync_d;
  logic             inc, rise;
  // Zero-extended divider copies: taps beyond DIV_W read constant 0, so they never tick.
  logic [15:0]      d_old_x, d_new_x;
  always_comb begin
    inc     = en & ~resync & (p_q == PW'(NPHASE - 1));
    rise    = sync_q[1] & ~sync_q[2];
    p_d     = resync ? '0 : !en ? p_q : inc ? '0 : p_q + 1'b1;
    d_d     = resync ? '0 : inc ? d_q + 1'b1 : d_q;
    d_old_x = 16'(d_q);
    d_new_x = 16'(d_d);
    // Old and new value are sampled with the same tap, so a tap change alone cannot tick.
    tick_d  = ~d_old_x[tap_sel] & d_new_x[tap_sel];
    wrap_d  = inc & (&d_q);
    sync_d  = resync ? 3'b000 : {sync_q[1:0], issi};
    // A new rise on the service edge keeps the request pending instead of overflowing.
    pend_d  = ~resync & (rise | (pend_q & ~issi_ph));
    ovf_d   = ~resync & (ovf_q | (rise & pend_q & ~issi_ph));
  end
  always_ff @(posedge _51KPHI or negedge rst_n) begin
    if (!rst_n) begin
      p_q    <= '0;
      d_q    <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
      sync_q <= 3'b000;
    end else begin
      p_q    <= p_d;
      d_q    <= d_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      sync_q <= sync_d;
    end
  end
  assign faz       = NPHASE'(1) << p_q;
  assign faz_n     = ~faz;
  assign phase_idx = p_q;
  assign div_cnt   = d_q;
  assign tick_out  = tick_q;
  assign wrap      = wrap_q;
  assign issi_ph   = pend_q & faz[ISSI_PH] & en;
  assign issi_pend = pend_q;
  assign issi_ovf  = ovf_q;
endmodule

// File: doc/cdu_timing_gen.md
CDU_TIMING_GEN -- requirements
Module: cdu_timing_gen

Interface
REQ-001 The block SHALL have parameter NPHASE, default 4, meaning the number of one-hot timing phases (legal 2..8).
REQ-002 The block SHALL have parameter DIV_W, default 4, meaning the width of the phase-cycle divider (legal 1..16).
REQ-003 The block SHALL have parameter ISSI_PH, default 2, meaning the phase index on which a synchronised ISSI request is serviced (legal 0..NPHASE-1).
REQ-004 The block SHALL have one clock and an asynchronous active-low reset, with ports as follows:
- _51KPHI  input  1  master clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  phase advance enable.
- resync  input  1  synchronous restart of phase, divider and ISSI state.
- tap_sel  input  4  divider bit selected for tick_out.
- issi  input  1  asynchronous ISSI request; level, not clock-aligned.
- faz  output  NPHASE  one-hot phase vector; faz[i] high in phase i.
- faz_n  output  NPHASE  bitwise complement of faz.
- phase_idx  output  clog2(NPHASE)  current phase index p.
- div_cnt  output  DIV_W  phase-cycle divider value d.
- tick_out  output  1  one-cycle strobe on the 0->1 transition of d[tap_sel].
- wrap  output  1  one-cycle strobe on divider wrap.
- issi_ph  output  1  one-cycle serviced-ISSI strobe, aligned to phase ISSI_PH.
- issi_pend  output  1  a synchronised ISSI request is waiting for service.
- issi_ovf  output  1  sticky flag: an ISSI request was merged into one already pending.

Function
REQ-005 Phase counter p SHALL advance by 1 on each clock with en=1, and SHALL return to 0 after NPHASE-1.
REQ-006 faz SHALL equal (1<<p) at all times and SHALL never be all-zero or multi-hot; faz_n SHALL equal ~faz.
REQ-007 Divider d SHALL increment modulo 2^DIV_W on each clock where en=1 and p=NPHASE-1.
REQ-008 wrap SHALL be registered and high for exactly one cycle following the edge at which d goes from all-ones to 0.
REQ-009 tick_out SHALL be registered and high for exactly one cycle following the edge at which d[tap_sel] goes from 0 to 1.
REQ-010 When tap_sel >= DIV_W, tick_out SHALL be held 0.
REQ-011 When en=0, p and d SHALL hold, and tick_out and wrap SHALL be 0 on the next cycle.
REQ-012 resync=1 SHALL take priority over en and the ISSI logic. On the next edge it SHALL force p=0, d=0, issi_pend=0, issi_ovf=0 and synchroniser flops=0, and tick_out=wrap=0.
REQ-013 The issi input SHALL pass through a two-flop synchroniser (s1, s2) followed by an edge register s3; a rising edge is rise = s2 & ~s3.
REQ-014 issi_pend SHALL set on the edge at which rise=1; latency from issi meeting setup at edge k to issi_pend=1 is edge k+2.
REQ-015 issi_ph SHALL be combinational: issi_pend & faz[ISSI_PH] & en.
REQ-016 issi_pend SHALL clear on the edge at which issi_ph=1, unless rise=1 on that same edge; in that case issi_pend SHALL stay 1 (the new request is kept, no overflow).
REQ-017 When rise=1 while issi_pend=1 and issi_ph=0, issi_ovf SHALL set. issi_ovf SHALL clear only on reset or resync.
REQ-018 Changing tap_sel mid-operation SHALL only affect transitions evaluated after the change; no spurious tick_out SHALL result from the select change alone.

Reset
REQ-019 rst_n=0 SHALL asynchronously force p=0, d=0, faz=...0001, faz_n=...1110, tick_out=0, wrap=0, issi_pend=0, issi_ovf=0, issi_ph=0, and synchroniser flops=0.
REQ-020 After rst_n deasserts, the first state change SHALL occur on the first rising edge of _51KPHI with en=1; assertion mid-sequence SHALL discard all state with no partial strobe.

Verification (NPHASE=4, DIV_W=4, ISSI_PH=2)
REQ-021 Reset release, en=1 held -> faz 0001,0010,0100,1000,0001 repeating; div_cnt +1 every 4 clocks; wrap pulses once every 64 clocks, first 1 cycle after div_cnt 15->0.
REQ-022 tap_sel=1 -> tick_out one-cycle pulse every 16 clocks, following div_cnt 1->2 and 5->6; tap_sel=5 -> tick_out never asserts over 256 clocks.
REQ-023 en dropped at p=1, d=3 for 10 clocks -> faz=0010, div_cnt=3 throughout, no strobes; sequence then resumes at p=2.
REQ-024 resync pulsed at p=2, d=9 with issi_pend=1 -> next cycle p=0, faz=0001, div_cnt=0, issi_pend=0, issi_ovf=0.
REQ-025 issi pulse of 3 clocks -> issi_pend=1 two edges later; issi_ph high during the next faz=0100 only, then issi_pend=0. A second pulse before service -> issi_ovf=1 and a single issi_ph.
REQ-026 rst_n asserted mid-cycle at p=3, d=15 -> all outputs at reset values immediately, without waiting for a clock edge; no wrap pulse after release.
